// File: rtl/frame_ctrl_pkg.sv
// Shared types and default constants for the frame transmit controller.
// Optional stall timeout is enabled by defining FRAME_CTRL_TIMEOUT_EN.
package frame_ctrl_pkg;

  // Frame sequencer phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int DEF_HDR_LEN = 4;
  localparam int DEF_HDR_AW  = 4;
  localparam int DEF_PAY_MAX = 4096;
  localparam int DEF_LEN_W   = 13;
  localparam int DEF_GAP_LEN = 2;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TMO_CYC = 256;

endpackage

// File: rtl/frame_tx_ctrl_if.sv
// Bus between the frame controller, the payload FIFO and the framing logic.
// master = the controller, slave = the surrounding datapath.
interface frame_tx_ctrl_if
  import frame_ctrl_pkg::*;
#(
  parameter int HDR_AW = DEF_HDR_AW,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              prg_full;
  logic              fifo_empty;
  logic              fifo_rd;
  logic              tx_ready;
  logic [LEN_W-1:0]  pay_len;
  logic              en;
  logic              h_en;
  logic [HDR_AW-1:0] hdr_addr;
  logic              sof;
  logic              eof;
  logic              abort;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    input  prg_full, fifo_empty, tx_ready, pay_len,
    output fifo_rd, en, h_en, hdr_addr, sof, eof, abort, frame_cnt
  );

  modport slave (
    output prg_full, fifo_empty, tx_ready, pay_len,
    input  fifo_rd, en, h_en, hdr_addr, sof, eof, abort, frame_cnt
  );
endinterface

// File: rtl/frame_len_cnt.sv
// Loadable up/down counter with a terminal-count flag (cnt == term).
// clr has priority over ld, ld over counting; inc and dec together hold.
module frame_len_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count selection
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == term);
endmodule

// File: rtl/frame_tx_ctrl.sv
// Frame sequencer: header walk, run-time length payload read, inter-frame gap.
// Honours tx_ready backpressure and FIFO-empty stalls, counts completed frames.
// Define FRAME_CTRL_TIMEOUT_EN to abort a frame after TMO_CYC consecutive
// empty cycles in the payload phase.
module frame_tx_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int HDR_LEN = DEF_HDR_LEN,
  parameter int HDR_AW  = DEF_HDR_AW,
  parameter int PAY_MAX = DEF_PAY_MAX,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int GAP_LEN = DEF_GAP_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  frame_tx_ctrl_if.master        bus
);
  localparam int     GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam int     TMO_W    = $clog2(TMO_CYC + 1);
  // With no gap the payload phase returns straight to IDLE
  localparam state_e POST_PAY = (GAP_LEN == 0) ? IDLE : GAP;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [HDR_AW-1:0] hdr_addr_q, hdr_addr_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              en_q, en_d;
  logic              h_en_q, h_en_d;

  logic              in_hdr, in_pay, in_gap;
  logic              fifo_rd_c, sof_c, eof_c, abort_c;
  logic              pay_tc, gap_done, hdr_last;
  logic [LEN_W-1:0]  len_clamped;

  assign in_hdr = (state_q == HDR);
  assign in_pay = (state_q == PAY);
  assign in_gap = (state_q == GAP);

  // Zero or oversize lengths fall back to the maximum frame size
  assign len_clamped = ((bus.pay_len == '0) || (bus.pay_len > LEN_W'(PAY_MAX)))
                       ? LEN_W'(PAY_MAX) : bus.pay_len;

  assign hdr_last  = (hdr_addr_q == HDR_AW'(HDR_LEN - 1));

  // Strobes are suppressed in the reset cycle so an interrupted frame never
  // reports an end or abort
  assign fifo_rd_c = in_pay & bus.tx_ready & ~bus.fifo_empty & ~rst;
  assign sof_c     = in_hdr & bus.tx_ready & (hdr_addr_q == '0) & ~rst;
  assign eof_c     = fifo_rd_c & pay_tc;

  // Payload beat counter, terminal at the last beat of the latched length
  frame_len_cnt #(.W(LEN_W)) u_pay_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (~in_pay),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (fifo_rd_c),
    .dec    (1'b0),
    .term   (len_q - 1'b1),
    .tc     (pay_tc)
  );

  generate
    if (GAP_LEN > 0) begin : g_gap
      // Gap cycle counter, terminal on the last idle cycle
      frame_len_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (~in_gap),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (in_gap),
        .dec    (1'b0),
        .term   (GAP_W'(GAP_LEN - 1)),
        .tc     (gap_done)
      );
    end else begin : g_no_gap
      assign gap_done = 1'b1;
    end
  endgenerate

`ifdef FRAME_CTRL_TIMEOUT_EN
  logic stall_tc;

  // Consecutive empty cycles in the payload phase; any read restarts it.
  // A tx_ready stall with data available neither counts nor clears.
  frame_len_cnt #(.W(TMO_W)) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (~in_pay | fifo_rd_c),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (in_pay & bus.fifo_empty),
    .dec    (1'b0),
    .term   (TMO_W'(TMO_CYC - 1)),
    .tc     (stall_tc)
  );

  assign abort_c = in_pay & bus.fifo_empty & stall_tc & ~rst;
`else
  assign abort_c = 1'b0;
`endif

  // Next-state and registered-output computation for the frame sequencer
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hdr_addr_d  = hdr_addr_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.prg_full) begin
          state_d    = HDR;
          len_d      = len_clamped;
          hdr_addr_d = '0;
        end
      end
      HDR: begin
        if (bus.tx_ready) begin
          if (hdr_last) begin
            state_d    = PAY;
            hdr_addr_d = '0;
          end else begin
            hdr_addr_d = hdr_addr_q + 1'b1;
          end
        end
      end
      PAY: begin
        if (eof_c) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = POST_PAY;
        end else if (abort_c) begin
          state_d     = POST_PAY;
        end
      end
      GAP: begin
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    en_d   = (state_d == HDR) || (state_d == PAY);
    h_en_d = (state_d == HDR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      hdr_addr_q  <= '0;
      frame_cnt_q <= '0;
      en_q        <= 1'b0;
      h_en_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hdr_addr_q  <= hdr_addr_d;
      frame_cnt_q <= frame_cnt_d;
      en_q        <= en_d;
      h_en_q      <= h_en_d;
    end
  end

  assign bus.fifo_rd   = fifo_rd_c;
  assign bus.sof       = sof_c;
  assign bus.eof       = eof_c;
  assign bus.abort     = abort_c;
  assign bus.en        = en_q;
  assign bus.h_en      = h_en_q;
  assign bus.hdr_addr  = hdr_addr_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_frame_tx_ctrl.sv
// Self-checking bench for frame_tx_ctrl with randomized backpressure and
// FIFO-empty stalls checked against a beat-counting frame model.
module tb_frame_tx_ctrl;
  localparam int HDR_LEN = 4;
  localparam int HDR_AW  = 4;
  localparam int PAY_MAX = 4096;
  localparam int LEN_W   = 13;
  localparam int GAP_LEN = 2;
  localparam int CNT_W   = 4;
  localparam int TMO_CYC = 5;

  typedef logic [HDR_AW+5:0] ovec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_tx_ctrl_if #(.HDR_AW(HDR_AW), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus_if ();

  frame_tx_ctrl #(
    .HDR_LEN(HDR_LEN), .HDR_AW(HDR_AW), .PAY_MAX(PAY_MAX), .LEN_W(LEN_W),
    .GAP_LEN(GAP_LEN), .CNT_W(CNT_W), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int frames = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clamp_len(input int l);
    return (l == 0 || l > PAY_MAX) ? PAY_MAX : l;
  endfunction

  function automatic ovec_t obs_vec();
    return {bus_if.en, bus_if.h_en, bus_if.hdr_addr, bus_if.sof,
            bus_if.eof, bus_if.fifo_rd, bus_if.abort};
  endfunction

  // Drive one frame from its IDLE request cycle through the gap.
  // rs_hb / rs_rc: drop tx_ready 3 cycles at that header beat / 2 cycles at that
  // payload read count; es_rc: hold fifo empty 10 cycles at that read count;
  // rst_rc: pulse reset at that read count. Negative disables each.
  task automatic do_frame(input int len, input int rdy_pct, input int emp_pct,
                          input bit hold, input int rs_hb, input int rs_rc,
                          input int es_rc, input int rst_rc,
                          output int rd, output int sof_at);
    int exp_reads, hb, stl, rdy_left, emp_left, guard;
    bit rdy, emp, e_rd, e_eof, e_ab, e_sof, fin, rst_hit, rs_h, rs_r, es;
    ovec_t exp_v, obs_v;
    exp_reads = clamp_len(len);
    hb = 0; rd = 0; stl = 0; rdy_left = 0; emp_left = 0; guard = 0;
    fin = 0; rst_hit = 0; rs_h = 0; rs_r = 0; es = 0; e_ab = 0;
    sof_at = -1;

    bus_if.prg_full   = 1'b1;
    bus_if.pay_len    = LEN_W'(len);
    bus_if.tx_ready   = 1'($urandom);
    bus_if.fifo_empty = 1'($urandom);
    @(negedge clk);
    total++;
    obs_v = obs_vec();
    if (obs_v !== '0) begin
      bad++;
      $display("FAIL idle_cycle: got %h expected 0", obs_v);
    end
    @(posedge clk); #1;
    bus_if.prg_full = hold;

    while (!fin) begin
      guard++;
      if (guard > 20000) begin
        total++; bad++;
        $display("FAIL frame_budget: reads %0d expected %0d within budget", rd, exp_reads);
        break;
      end
      if (rs_hb >= 0 && !rs_h && hb < HDR_LEN && hb == rs_hb) begin rdy_left = 3; rs_h = 1; end
      if (rs_rc >= 0 && !rs_r && hb == HDR_LEN && rd == rs_rc) begin rdy_left = 2; rs_r = 1; end
      if (es_rc >= 0 && !es && hb == HDR_LEN && rd == es_rc) begin emp_left = 10; es = 1; end
      if (rdy_left > 0) begin rdy = 0; rdy_left--; end
      else rdy = ($urandom_range(99) < rdy_pct);
      if (emp_left > 0) begin emp = 1; emp_left--; end
      else emp = ($urandom_range(99) < emp_pct);

      if (rst_rc >= 0 && hb == HDR_LEN && rd == rst_rc) begin
        bus_if.tx_ready = 1'b1; bus_if.fifo_empty = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.prg_full = 1'b0;
        @(negedge clk);
        total++;
        obs_v = obs_vec();
        if ({obs_v, bus_if.frame_cnt} !== '0) begin
          bad++;
          $display("FAIL reset_mid_frame: outputs %h frame_cnt %0d expected all 0", obs_v, bus_if.frame_cnt);
        end
        exp_cnt = 0;
        rst_hit = 1;
        @(posedge clk); #1;
        break;
      end

      bus_if.tx_ready   = rdy;
      bus_if.fifo_empty = emp;
      e_ab = 0;
      if (hb < HDR_LEN) begin
        e_sof = (hb == 0) && rdy;
        exp_v = {1'b1, 1'b1, HDR_AW'(hb), e_sof, 1'b0, 1'b0, 1'b0};
      end else begin
        e_rd  = rdy && !emp;
        e_eof = e_rd && (rd == exp_reads - 1);
`ifdef FRAME_CTRL_TIMEOUT_EN
        e_ab  = emp && (stl + 1 == TMO_CYC);
`endif
        exp_v = {1'b1, 1'b0, HDR_AW'(0), 1'b0, e_eof, e_rd, e_ab};
      end

      @(negedge clk);
      total++;
      obs_v = obs_vec();
      if (obs_v !== exp_v) begin
        bad++;
        if (bad < 40)
          $display("FAIL beat hb=%0d rd=%0d: got {en,h_en,addr,sof,eof,rd,abort}=%h expected %h",
                   hb, rd, obs_v, exp_v);
      end
      if (bus_if.sof === 1'b1 && sof_at < 0) sof_at = cyc;

      if (hb < HDR_LEN) begin
        if (rdy) hb++;
      end else begin
        if (emp) stl++;
        else if (rdy) begin stl = 0; rd++; end
        if (rd == exp_reads || e_ab) fin = 1;
      end
      @(posedge clk); #1;
    end

    if (!rst_hit) begin
      for (int g = 0; g < GAP_LEN; g++) begin
        bus_if.tx_ready   = 1'($urandom);
        bus_if.fifo_empty = 1'($urandom);
        @(negedge clk);
        total++;
        obs_v = obs_vec();
        if (obs_v !== '0) begin
          bad++;
          $display("FAIL gap_cycle %0d: got %h expected 0", g, obs_v);
        end
        @(posedge clk); #1;
      end
      if (!e_ab) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      total++;
      if (int'(bus_if.frame_cnt) !== exp_cnt) begin
        bad++;
        $display("FAIL frame_cnt: got %0d expected %0d", bus_if.frame_cnt, exp_cnt);
      end
    end
    frames++;
    $display("frame %0d: pay_len=%0d reads=%0d abort=%0d reset=%0d frame_cnt=%0d",
             frames, len, rd, e_ab, rst_hit, bus_if.frame_cnt);
  endtask

  task automatic test_reset();
    ovec_t obs_v;
    rst = 1'b1;
    bus_if.prg_full = 1'b1; bus_if.fifo_empty = 1'b0;
    bus_if.tx_ready = 1'b1; bus_if.pay_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    obs_v = obs_vec();
    if (obs_v !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0", obs_v);
    end
    total++;
    if (bus_if.frame_cnt !== '0) begin
      bad++;
      $display("FAIL reset_frame_cnt: got %0d expected 0", bus_if.frame_cnt);
    end
    bus_if.prg_full = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    int rd, s;
    do_frame(8, 100, 0, 1'b0, -1, -1, -1, -1, rd, s);
    total++;
    if (rd !== 8) begin bad++; $display("FAIL basic_reads: got %0d expected 8", rd); end
  endtask

  task automatic test_backpressure();
    int rd, s;
    do_frame(8, 100, 0, 1'b0, 2, 4, -1, -1, rd, s);
    total++;
    if (rd !== 8) begin bad++; $display("FAIL backpressure_reads: got %0d expected 8", rd); end
    do_frame(8, 50, 0, 1'b0, -1, -1, -1, -1, rd, s);
    total++;
    if (rd !== 8) begin bad++; $display("FAIL random_ready_reads: got %0d expected 8", rd); end
  endtask

  task automatic test_empty_stall();
    int rd, s, want;
`ifdef FRAME_CTRL_TIMEOUT_EN
    want = (TMO_CYC <= 10) ? 4 : 8;
`else
    want = 8;
`endif
    do_frame(8, 100, 0, 1'b0, -1, -1, 4, -1, rd, s);
    total++;
    if (rd !== want) begin bad++; $display("FAIL empty_stall_reads: got %0d expected %0d", rd, want); end
  endtask

  task automatic test_clamp();
    int lens[4] = '{0, 5000, 4096, 1};
    int rd, s;
    foreach (lens[i]) begin
      do_frame(lens[i], 100, 0, 1'b0, -1, -1, -1, -1, rd, s);
      total++;
      if (rd !== clamp_len(lens[i])) begin
        bad++;
        $display("FAIL clamp_reads len=%0d: got %0d expected %0d", lens[i], rd, clamp_len(lens[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int rd, s;
    do_frame(8, 100, 0, 1'b0, -1, -1, -1, 3, rd, s);
    do_frame(6, 100, 0, 1'b0, -1, -1, -1, -1, rd, s);
    total++;
    if (rd !== 6 || s < 0) begin
      bad++;
      $display("FAIL post_reset_frame: reads %0d sof_cycle %0d expected 6 reads with sof", rd, s);
    end
  endtask

  task automatic test_back_to_back();
    int rd, s1, s2;
    do_frame(5, 100, 0, 1'b1, -1, -1, -1, -1, rd, s1);
    do_frame(7, 100, 0, 1'b1, -1, -1, -1, -1, rd, s2);
    bus_if.prg_full = 1'b0;
    total++;
    if (s2 - s1 !== HDR_LEN + 5 + GAP_LEN + 1) begin
      bad++;
      $display("FAIL sof_spacing: got %0d expected %0d", s2 - s1, HDR_LEN + 5 + GAP_LEN + 1);
    end
  endtask

  task automatic test_random_wrap();
    int rd, s, n;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    n = 0;
    for (int f = 0; f < (1 << CNT_W) + 1; f++) begin
      do_frame($urandom_range(40, 1), $urandom_range(100, 40), $urandom_range(20, 0),
               1'($urandom), -1, -1, -1, -1, rd, s);
      n++;
    end
    bus_if.prg_full = 1'b0;
    total++;
    if (int'(bus_if.frame_cnt) !== exp_cnt) begin
      bad++;
      $display("FAIL wrap_frame_cnt after %0d frames: got %0d expected %0d", n, bus_if.frame_cnt, exp_cnt);
    end
  endtask

  initial begin
    bus_if.prg_full = 1'b0; bus_if.fifo_empty = 1'b1;
    bus_if.tx_ready = 1'b0; bus_if.pay_len = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    test_random_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
